// File: rtl/gray_ptr_rx.sv
// Receive side of a gray-coded pointer crossing into the clk domain.
// Synchronizes, decodes to binary, reports the step size and flags protocol violations.
module gray_ptr_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit STRICT      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             error_clear,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta,
    output logic             delta_valid,
    output logic             error
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] g_sync, g_prev, b, d, gx;
    logic             backward, multi, err_set;

    assign g_sync = sync_q[SYNC_STAGES-1];

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        b = '0;
        b[WIDTH-1] = g_sync[WIDTH-1];
        for (int i = WIDTH-2; i >= 0; i--)
            b[i] = b[i+1] ^ g_sync[i];
    end

    assign d        = b - bin_out;
    assign backward = d[WIDTH-1];
    assign gx       = g_sync ^ g_prev;
    // Clearing the lowest set bit leaves something only if more than one bit flipped.
    assign multi    = |(gx & (gx - ONE));
    assign err_set  = backward | (STRICT & multi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_prev      <= '0;
            bin_out     <= '0;
            delta       <= '0;
            delta_valid <= 1'b0;
            error       <= 1'b0;
        end else begin
            g_prev      <= g_sync;
            bin_out     <= b;
            delta_valid <= (d != '0);
            // delta keeps the last step size; delta_valid marks when it is fresh.
            if (d != '0)
                delta <= d;
            error <= err_set | (error & ~error_clear);
        end
    end
endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx: one STRICT=1 and one STRICT=0 instance share the stimulus.
module tb_gray_ptr_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] gray_in = 4'b0101;
    logic       error_clear = 1'b0;

    logic [3:0] bin_s, delta_s, bin_n, delta_n;
    logic       dv_s, err_s, dv_n, err_n;
    logic [9:0] os, on;

    int pass_cnt = 0;
    int total    = 0;

    gray_ptr_rx #(.WIDTH(4), .SYNC_STAGES(2), .STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .gray_in(gray_in), .error_clear(error_clear),
        .bin_out(bin_s), .delta(delta_s), .delta_valid(dv_s), .error(err_s));

    gray_ptr_rx #(.WIDTH(4), .SYNC_STAGES(2), .STRICT(1'b0)) dut_n (
        .clk(clk), .reset(reset), .gray_in(gray_in), .error_clear(error_clear),
        .bin_out(bin_n), .delta(delta_n), .delta_valid(dv_n), .error(err_n));

    assign os = {bin_s, delta_s, dv_s, err_s};
    assign on = {bin_n, delta_n, dv_n, err_n};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a gray value and wait through capture, sync and output edges.
    task automatic step_to(input logic [3:0] g);
        gray_in = g;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if (os !== 10'b0) $display("FAIL reset_s got %b exp %b", os, 10'b0); else pass_cnt++;
        total++;
        if (on !== 10'b0) $display("FAIL reset_n got %b exp %b", on, 10'b0); else pass_cnt++;
        reset = 1'b0;
        gray_in = 4'b0000;
        repeat (4) tick();
        total++;
        if (os !== 10'b0) $display("FAIL post_reset_s got %b exp %b", os, 10'b0); else pass_cnt++;
        total++;
        if (on !== 10'b0) $display("FAIL post_reset_n got %b exp %b", on, 10'b0); else pass_cnt++;
    endtask

    task automatic test_single_step();
        gray_in = 4'b0001;
        tick();
        tick();
        total++;
        if ({bin_s, dv_s} !== 5'b0000_0) $display("FAIL step_early got %b exp %b", {bin_s, dv_s}, 5'b0000_0);
        else pass_cnt++;
        tick();
        total++;
        if (os !== {4'd1, 4'd1, 1'b1, 1'b0}) $display("FAIL step_s got %b exp %b", os, {4'd1, 4'd1, 1'b1, 1'b0});
        else pass_cnt++;
        total++;
        if (on !== {4'd1, 4'd1, 1'b1, 1'b0}) $display("FAIL step_n got %b exp %b", on, {4'd1, 4'd1, 1'b1, 1'b0});
        else pass_cnt++;
        tick();
        total++;
        if ({bin_s, dv_s, err_s} !== 6'b0001_0_0) $display("FAIL step_pulse_end got %b exp %b", {bin_s, dv_s, err_s}, 6'b0001_0_0);
        else pass_cnt++;
    endtask

    task automatic test_wraparound();
        for (int bv = 2; bv < 16; bv++) begin
            logic [3:0] bb;
            bb = 4'(bv);
            step_to(bb ^ (bb >> 1));
        end
        total++;
        if ({bin_s, err_s, bin_n, err_n} !== 10'b1111_0_1111_0)
            $display("FAIL walk15 got %b exp %b", {bin_s, err_s, bin_n, err_n}, 10'b1111_0_1111_0);
        else pass_cnt++;
        step_to(4'b0000);
        total++;
        if (os !== {4'd0, 4'd1, 1'b1, 1'b0}) $display("FAIL wrap_s got %b exp %b", os, {4'd0, 4'd1, 1'b1, 1'b0});
        else pass_cnt++;
        total++;
        if (on !== {4'd0, 4'd1, 1'b1, 1'b0}) $display("FAIL wrap_n got %b exp %b", on, {4'd0, 4'd1, 1'b1, 1'b0});
        else pass_cnt++;
        tick();
        total++;
        if ({dv_s, dv_n} !== 2'b00) $display("FAIL wrap_pulse_end got %b exp %b", {dv_s, dv_n}, 2'b00);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        step_to(4'b0011);
        total++;
        if (os !== {4'd2, 4'd2, 1'b1, 1'b1}) $display("FAIL jump_strict got %b exp %b", os, {4'd2, 4'd2, 1'b1, 1'b1});
        else pass_cnt++;
        total++;
        if (on !== {4'd2, 4'd2, 1'b1, 1'b0}) $display("FAIL jump_loose got %b exp %b", on, {4'd2, 4'd2, 1'b1, 1'b0});
        else pass_cnt++;
        step_to(4'b0010);
        total++;
        if ({bin_s, err_s, err_n} !== 6'b0011_1_0) $display("FAIL jump_sticky got %b exp %b", {bin_s, err_s, err_n}, 6'b0011_1_0);
        else pass_cnt++;
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        total++;
        if (err_s !== 1'b0) $display("FAIL jump_clear got %b exp %b", err_s, 1'b0); else pass_cnt++;
    endtask

    task automatic test_backward_clear();
        step_to(4'b0110);
        step_to(4'b0111);
        total++;
        if ({bin_s, err_s} !== 5'b0101_0) $display("FAIL at5 got %b exp %b", {bin_s, err_s}, 5'b0101_0);
        else pass_cnt++;
        step_to(4'b0110);
        total++;
        if (os !== {4'd4, 4'd15, 1'b1, 1'b1}) $display("FAIL back_s got %b exp %b", os, {4'd4, 4'd15, 1'b1, 1'b1});
        else pass_cnt++;
        total++;
        if (on !== {4'd4, 4'd15, 1'b1, 1'b1}) $display("FAIL back_n got %b exp %b", on, {4'd4, 4'd15, 1'b1, 1'b1});
        else pass_cnt++;
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        total++;
        if ({err_s, err_n} !== 2'b00) $display("FAIL clear got %b exp %b", {err_s, err_n}, 2'b00); else pass_cnt++;
        // Clear lands on the same edge that sees another backward step.
        gray_in = 4'b0010;
        tick();
        tick();
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        total++;
        if ({bin_s, delta_s, err_s, err_n} !== 10'b0011_1111_1_1)
            $display("FAIL set_wins got %b exp %b", {bin_s, delta_s, err_s, err_n}, 10'b0011_1111_1_1);
        else pass_cnt++;
        tick();
        total++;
        if ({err_s, err_n} !== 2'b11) $display("FAIL set_sticky got %b exp %b", {err_s, err_n}, 2'b11); else pass_cnt++;
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
    endtask

    task automatic test_async_reset();
        step_to(4'b0110);
        step_to(4'b0111);
        step_to(4'b0101);
        step_to(4'b0100);
        step_to(4'b1100);
        step_to(4'b1101);
        step_to(4'b1100);
        step_to(4'b1101);
        total++;
        if ({bin_s, err_s, bin_n, err_n} !== 10'b1001_1_1001_1)
            $display("FAIL at9 got %b exp %b", {bin_s, err_s, bin_n, err_n}, 10'b1001_1_1001_1);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (os !== 10'b0) $display("FAIL async_s got %b exp %b", os, 10'b0); else pass_cnt++;
        total++;
        if (on !== 10'b0) $display("FAIL async_n got %b exp %b", on, 10'b0); else pass_cnt++;
        gray_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if (os !== 10'b0) $display("FAIL async_release got %b exp %b", os, 10'b0); else pass_cnt++;
        step_to(4'b0001);
        total++;
        if (os !== {4'd1, 4'd1, 1'b1, 1'b0}) $display("FAIL async_step got %b exp %b", os, {4'd1, 4'd1, 1'b1, 1'b0});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wraparound();
        test_jump();
        test_backward_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Receiving end of a gray-coded pointer that crosses into the local clock domain, as used by the FIFOs between the fractal compute and LCD pixel domains. The block synchronizes an asynchronous gray-coded pointer, decodes it to binary, and reports the number of increments since the previous sample. It also flags protocol violations in a sticky error bit: a pointer that moves backwards, or (optionally) a pointer that changes more than one bit between samples. It sits directly after the clock-domain boundary and feeds full/empty or occupancy logic.

## Interface
- WIDTH, 4, pointer width in bits (≥2)
- SYNC_STAGES, 2, synchronizer flop count (≥2)
- STRICT, 1, 1 = raise error when consecutive synced gray values differ in more than one bit; 0 = allow multi-step jumps (source clock faster than clk)

- clk  in  1  local clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- gray_in  in  WIDTH  gray-coded pointer from the remote domain, asynchronous to clk
- error_clear  in  1  synchronous clear of error
- bin_out  out  WIDTH  decoded binary pointer
- delta  out  WIDTH  increments since previous bin_out, modulo 2^WIDTH
- delta_valid  out  1  single-cycle pulse when delta is nonzero
- error  out  1  sticky protocol-violation flag

## Operation
- Synchronizer: SYNC_STAGES-deep flop chain on gray_in; no logic between stages. Output is g_sync.
- g_prev register holds the previous g_sync.
- Decode: b[WIDTH-1] = g_sync[WIDTH-1]; b[i] = b[i+1] ^ g_sync[i] for i below. Purely combinational between g_sync and the output register.
- Each cycle, registered:
  - bin_out ← b
  - d = (b − bin_out) mod 2^WIDTH, computed at WIDTH bits with wraparound
  - delta ← d
  - delta_valid ← (d != 0)
- Error set conditions, evaluated in the same cycle as the bin_out update:
  - backward: d ≥ 2^(WIDTH-1)
  - STRICT=1 only: popcount(g_sync ^ g_prev) > 1
- error is sticky until error_clear=1. If set and clear coincide, set wins and error stays 1.
- Wraparound from 2^WIDTH−1 to 0 is a legal step: d = 1, no error.
- delta and bin_out hold their values between updates. delta_valid is low whenever d = 0.

## Timing
- Reset (async assert, release synchronous to clk): the synchronizer chain, g_prev, bin_out, delta, delta_valid and error all go to 0. The remote writer also resets to pointer 0, so the first post-reset step reports delta = 1.
- Reset mid-operation: all outputs go to 0 immediately, with no clock required. Any pending synchronizer contents are discarded.
- Latency: a stable change on gray_in is captured by stage 1 at edge k. g_sync reflects it after edge k+SYNC_STAGES−1. bin_out, delta, delta_valid and error update at edge k+SYNC_STAGES. With default SYNC_STAGES=2 this is 2 edges after capture, so 2–3 edges after the change depending on setup.
- A gray_in value that is metastable at capture resolves to either the old or the new value. Either result is legal and yields delta 0 or 1.
- Throughput: one new pointer sample per clk cycle. No handshake and no backpressure.

## Test plan
- Reset: drive gray_in=0101 while reset=1 → bin_out=0, delta=0, delta_valid=0, error=0. Release reset, hold gray_in=0000 → outputs stay 0.
- Single step: gray_in 0000→0001 → exactly 2 edges after capture bin_out=1, delta=1, delta_valid high for exactly one cycle, error=0.
- Wraparound: walk the pointer to bin 15 (gray 1000), then gray_in=0000 → bin_out=0, delta=1, single delta_valid pulse, error=0.
- Multi-step jump: from 0000 apply 0011 (bin 2). STRICT=0 → delta=2, error=0. STRICT=1 → delta=2, error=1, and error stays 1 through later legal steps.
- Backward and clear: from bin 5 (gray 0111) apply 0110 (bin 4) → delta=15, error=1. Pulse error_clear alone → error=0 next cycle. Assert error_clear in the same cycle as another backward step → error remains 1.
- Async reset mid-stream: step the pointer to bin 9, assert reset between clock edges → all outputs 0 before the next edge. After release, step gray_in to 0001 → delta=1.
